// File: rtl/ysyx_22040759_axi_rd_master.sv
// Single-beat AXI4 read master serving one arbiter request at a time.
//
// A request (rd_addr_valid_i with rd_addr_i / rd_size_i) is captured in IDLE.
// One AR beat (len 0, INCR) is issued from the captured values. R beats with a
// foreign ID or without RLAST are accepted and dropped. The final matching beat
// is aligned to the request address, zero-extended, and returned as a one-cycle
// rd_data_valid_o pulse (with rd_err_o when RRESP != OKAY). After each response
// the master ignores new requests for GAP_CYCLES cycles.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   rd_addr_valid_i          request valid (level, held until captured)
//   rd_addr_i, rd_size_i     request byte address and size (00=1B .. 11=8B)
//   rd_data_valid_o          one-cycle pulse, rd_data_o valid
//   rd_data_o                aligned, zero-extended read data (held)
//   rd_err_o                 pulses with rd_data_valid_o on a non-OKAY response
//   axi_ar_*                 AXI read address channel
//   axi_r_*                  AXI read data channel
module ysyx_22040759_axi_rd_master #(
   parameter logic [3:0]  AXI_ID     = 4'h0,
   parameter int unsigned GAP_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rd_addr_valid_i,
   input  logic [63:0] rd_addr_i,
   input  logic [1:0]  rd_size_i,
   output logic        rd_data_valid_o,
   output logic [63:0] rd_data_o,
   output logic        rd_err_o,
   output logic        axi_ar_valid_o,
   input  logic        axi_ar_ready_i,
   output logic [63:0] axi_ar_addr_o,
   output logic [3:0]  axi_ar_id_o,
   output logic [7:0]  axi_ar_len_o,
   output logic [2:0]  axi_ar_size_o,
   output logic [1:0]  axi_ar_burst_o,
   input  logic        axi_r_valid_i,
   output logic        axi_r_ready_o,
   input  logic [63:0] axi_r_data_i,
   input  logic [1:0]  axi_r_resp_i,
   input  logic        axi_r_last_i,
   input  logic [3:0]  axi_r_id_i
);

   localparam int unsigned CntW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

   typedef enum logic [1:0] {
      StIdle,
      StAddr,
      StData,
      StGap
   } state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] gap_cnt_q, gap_cnt_d;
   logic [63:0]     addr_q, addr_d;
   logic [1:0]      size_q, size_d;
   logic [63:0]     data_q, data_d;
   logic            valid_q, valid_d;
   logic            err_q, err_d;

   logic [63:0]     shifted;
   logic [63:0]     aligned;
   logic            final_beat;

   // Bring the addressed byte lane down to bit 0, then keep only the requested width.
   always_comb begin
      shifted = axi_r_data_i >> {addr_q[2:0], 3'b000};
      aligned = '0;
      unique case (size_q)
         2'b00:   aligned = {56'd0, shifted[7:0]};
         2'b01:   aligned = {48'd0, shifted[15:0]};
         2'b10:   aligned = {32'd0, shifted[31:0]};
         default: aligned = shifted;
      endcase
   end

   assign final_beat = axi_r_valid_i && (axi_r_id_i == AXI_ID) && axi_r_last_i;

   always_comb begin
      state_d   = state_q;
      gap_cnt_d = gap_cnt_q;
      addr_d    = addr_q;
      size_d    = size_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      err_d     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (rd_addr_valid_i) begin
               addr_d  = rd_addr_i;
               size_d  = rd_size_i;
               state_d = StAddr;
            end
         end
         StAddr: begin
            if (axi_ar_ready_i) begin
               state_d = StData;
            end
         end
         StData: begin
            // r_ready is high here, so every valid beat is consumed; only the last
            // matching beat carries the response.
            if (final_beat) begin
               data_d  = aligned;
               valid_d = 1'b1;
               err_d   = (axi_r_resp_i != 2'b00);
               if (GAP_CYCLES == 0) begin
                  state_d = StIdle;
               end else begin
                  state_d   = StGap;
                  gap_cnt_d = CntW'(GAP_CYCLES);
               end
            end
         end
         StGap: begin
            // The counter value is the number of GAP cycles still to spend,
            // including the current one.
            if (gap_cnt_q <= CntW'(1)) begin
               gap_cnt_d = '0;
               state_d   = StIdle;
            end else begin
               gap_cnt_d = gap_cnt_q - 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         gap_cnt_q <= '0;
         addr_q    <= '0;
         size_q    <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         gap_cnt_q <= gap_cnt_d;
         addr_q    <= addr_d;
         size_q    <= size_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
      end
   end

   assign rd_data_valid_o = valid_q;
   assign rd_data_o       = data_q;
   assign rd_err_o        = err_q;

   assign axi_ar_valid_o  = (state_q == StAddr);
   assign axi_ar_addr_o   = addr_q;
   assign axi_ar_id_o     = AXI_ID;
   assign axi_ar_len_o    = 8'd0;
   assign axi_ar_size_o   = {1'b0, size_q};
   assign axi_ar_burst_o  = 2'b01;

   assign axi_r_ready_o   = (state_q == StData);

endmodule

// File: tb/tb_ysyx_22040759_axi_rd_master.sv
module tb_ysyx_22040759_axi_rd_master;

   localparam logic [3:0] AxiId = 4'h0;

   logic        clk;
   logic        rst;
   logic        rd_addr_valid_i;
   logic [63:0] rd_addr_i;
   logic [1:0]  rd_size_i;
   logic        rd_data_valid_o;
   logic [63:0] rd_data_o;
   logic        rd_err_o;
   logic        axi_ar_valid_o;
   logic        axi_ar_ready_i;
   logic [63:0] axi_ar_addr_o;
   logic [3:0]  axi_ar_id_o;
   logic [7:0]  axi_ar_len_o;
   logic [2:0]  axi_ar_size_o;
   logic [1:0]  axi_ar_burst_o;
   logic        axi_r_valid_i;
   logic        axi_r_ready_o;
   logic [63:0] axi_r_data_i;
   logic [1:0]  axi_r_resp_i;
   logic        axi_r_last_i;
   logic [3:0]  axi_r_id_i;

   ysyx_22040759_axi_rd_master #(
      .AXI_ID     (AxiId),
      .GAP_CYCLES (2)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .rd_addr_valid_i (rd_addr_valid_i),
      .rd_addr_i       (rd_addr_i),
      .rd_size_i       (rd_size_i),
      .rd_data_valid_o (rd_data_valid_o),
      .rd_data_o       (rd_data_o),
      .rd_err_o        (rd_err_o),
      .axi_ar_valid_o  (axi_ar_valid_o),
      .axi_ar_ready_i  (axi_ar_ready_i),
      .axi_ar_addr_o   (axi_ar_addr_o),
      .axi_ar_id_o     (axi_ar_id_o),
      .axi_ar_len_o    (axi_ar_len_o),
      .axi_ar_size_o   (axi_ar_size_o),
      .axi_ar_burst_o  (axi_ar_burst_o),
      .axi_r_valid_i   (axi_r_valid_i),
      .axi_r_ready_o   (axi_r_ready_o),
      .axi_r_data_i    (axi_r_data_i),
      .axi_r_resp_i    (axi_r_resp_i),
      .axi_r_last_i    (axi_r_last_i),
      .axi_r_id_i      (axi_r_id_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] addr;
      logic [1:0]  size;
      logic [63:0] rdata;
      logic [1:0]  resp;
      int          ar_wait;
      int          wrong_id;
      int          nonlast;
      logic [63:0] exp_data;
      logic        exp_err;
   } vec_t;

   typedef struct packed {
      logic [63:0] data;
      logic        err;
   } exp_t;

   localparam int NumVecs = 11;
   vec_t vecs [NumVecs];
   exp_t sb [$];

   int checks = 0;
   int errors = 0;
   logic prev_valid = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s: bound expired", name);
   endtask

   // Scoreboard consumer: every rd_data_valid_o pulse must match a queued expectation.
   always @(negedge clk) begin
      if (!rst) begin
         check("err_only_with_valid", {63'd0, rd_err_o & ~rd_data_valid_o}, 64'd0);
         if (rd_data_valid_o) begin
            check("valid_pulse_width", {63'd0, prev_valid}, 64'd0);
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_valid: got data %h, none expected", rd_data_o);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("rd_data", rd_data_o, e.data);
               check("rd_err", {63'd0, rd_err_o}, {63'd0, e.err});
            end
         end
      end
      prev_valid <= rd_data_valid_o;
   end

   task automatic wait_sb_empty(input string name);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         fail_now(name);
         sb.delete();
      end
   endtask

   task automatic wait_ar_valid(input string name, output bit ok);
      int n;
      n = 0;
      @(negedge clk);
      while (!axi_ar_valid_o && n < 20) begin
         @(negedge clk);
         n++;
      end
      ok = axi_ar_valid_o;
      if (!ok) fail_now(name);
   endtask

   task automatic do_read(input vec_t v);
      bit ok;
      rd_addr_valid_i = 1'b1;
      rd_addr_i       = v.addr;
      rd_size_i       = v.size;
      wait_ar_valid("ar_valid_timeout", ok);
      if (!ok) begin
         rd_addr_valid_i = 1'b0;
         return;
      end
      // Post-capture request changes must not leak onto AR.
      rd_addr_valid_i = 1'b0;
      rd_addr_i       = ~v.addr;
      rd_size_i       = ~v.size;
      check("ar_addr", axi_ar_addr_o, v.addr);
      check("ar_size", {61'd0, axi_ar_size_o}, {62'd0, v.size});
      for (int i = 0; i < v.ar_wait; i++) begin
         @(posedge clk);
         @(negedge clk);
         check("ar_valid_held", {63'd0, axi_ar_valid_o}, 64'd1);
         check("ar_addr_stable", axi_ar_addr_o, v.addr);
         check("r_ready_in_addr", {63'd0, axi_r_ready_o}, 64'd0);
      end
      axi_ar_ready_i = 1'b1;
      @(posedge clk);
      #1 axi_ar_ready_i = 1'b0;
      @(negedge clk);
      check("r_ready_in_data", {63'd0, axi_r_ready_o}, 64'd1);
      check("ar_valid_in_data", {63'd0, axi_ar_valid_o}, 64'd0);
      for (int i = 0; i < v.wrong_id; i++) begin
         axi_r_valid_i = 1'b1;
         axi_r_id_i    = 4'h3;
         axi_r_last_i  = 1'b1;
         axi_r_resp_i  = 2'b00;
         axi_r_data_i  = {$urandom, $urandom};
         @(posedge clk);
         #1;
      end
      for (int i = 0; i < v.nonlast; i++) begin
         axi_r_valid_i = 1'b1;
         axi_r_id_i    = AxiId;
         axi_r_last_i  = 1'b0;
         axi_r_resp_i  = 2'b10;
         axi_r_data_i  = {$urandom, $urandom};
         @(posedge clk);
         #1;
      end
      axi_r_valid_i = 1'b1;
      axi_r_id_i    = AxiId;
      axi_r_last_i  = 1'b1;
      axi_r_resp_i  = v.resp;
      axi_r_data_i  = v.rdata;
      sb.push_back('{data: v.exp_data, err: v.exp_err});
      @(posedge clk);
      #1;
      axi_r_valid_i = 1'b0;
      axi_r_last_i  = 1'b0;
      wait_sb_empty("response_timeout");
      repeat (3) @(negedge clk);
      check("rd_data_hold", rd_data_o, v.exp_data);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      vecs[0]  = '{64'h8000_0004, 2'b10, 64'h1122_3344_5566_7788, 2'b00, 0, 0, 0,
                   64'h0000_0000_1122_3344, 1'b0};
      vecs[1]  = '{64'h8000_0007, 2'b00, 64'h0000_0000_0000_00FF, 2'b00, 0, 1, 0,
                   64'h0, 1'b0};
      vecs[2]  = '{64'h0000_0000, 2'b11, 64'h0123_4567_89AB_CDEF, 2'b00, 1, 0, 0,
                   64'h0123_4567_89AB_CDEF, 1'b0};
      vecs[3]  = '{64'h0000_0001, 2'b00, 64'h0123_4567_89AB_CDEF, 2'b00, 0, 0, 0,
                   64'h0000_0000_0000_00CD, 1'b0};
      vecs[4]  = '{64'h0000_0002, 2'b01, 64'h0123_4567_89AB_CDEF, 2'b00, 2, 0, 0,
                   64'h0000_0000_0000_89AB, 1'b0};
      vecs[5]  = '{64'h0000_0006, 2'b01, 64'h0123_4567_89AB_CDEF, 2'b00, 0, 0, 0,
                   64'h0000_0000_0000_0123, 1'b0};
      vecs[6]  = '{64'h0000_0004, 2'b11, 64'h0123_4567_89AB_CDEF, 2'b00, 0, 0, 0,
                   64'h0000_0000_0123_4567, 1'b0};
      vecs[7]  = '{64'h0000_0000, 2'b10, 64'hDEAD_BEEF_CAFE_F00D, 2'b10, 0, 0, 0,
                   64'h0000_0000_CAFE_F00D, 1'b1};
      vecs[8]  = '{64'h0000_0003, 2'b00, 64'h0123_4567_89AB_CDEF, 2'b11, 0, 0, 0,
                   64'h0000_0000_0000_0089, 1'b1};
      vecs[9]  = '{64'h0000_1000, 2'b11, 64'h5555_AAAA_5555_AAAA, 2'b00, 5, 0, 0,
                   64'h5555_AAAA_5555_AAAA, 1'b0};
      vecs[10] = '{64'h0000_2005, 2'b00, 64'h0011_2233_4455_6677, 2'b01, 0, 2, 2,
                   64'h0000_0000_0000_0022, 1'b1};

      rst             = 1'b1;
      rd_addr_valid_i = 1'b0;
      rd_addr_i       = '0;
      rd_size_i       = '0;
      axi_ar_ready_i  = 1'b0;
      axi_r_valid_i   = 1'b0;
      axi_r_data_i    = '0;
      axi_r_resp_i    = '0;
      axi_r_last_i    = 1'b0;
      axi_r_id_i      = '0;

      repeat (3) @(negedge clk);
      check("rst_ar_valid", {63'd0, axi_ar_valid_o}, 64'd0);
      check("rst_r_ready", {63'd0, axi_r_ready_o}, 64'd0);
      check("rst_data_valid", {63'd0, rd_data_valid_o}, 64'd0);
      check("rst_err", {63'd0, rd_err_o}, 64'd0);
      check("rst_rd_data", rd_data_o, 64'd0);
      check("rst_ar_addr", axi_ar_addr_o, 64'd0);
      check("rst_ar_size", {61'd0, axi_ar_size_o}, 64'd0);
      check("rst_ar_id", {60'd0, axi_ar_id_o}, {60'd0, AxiId});
      check("rst_ar_len", {56'd0, axi_ar_len_o}, 64'd0);
      check("rst_ar_burst", {62'd0, axi_ar_burst_o}, 64'd1);
      rst = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < NumVecs; i++) do_read(vecs[i]);

      // Back-to-back latency with ar_ready and r_valid held high, then the cooldown gap.
      repeat (4) @(posedge clk);
      #1;
      rd_addr_valid_i = 1'b1;
      rd_addr_i       = 64'h10;
      rd_size_i       = 2'b11;
      axi_ar_ready_i  = 1'b1;
      axi_r_valid_i   = 1'b1;
      axi_r_id_i      = AxiId;
      axi_r_last_i    = 1'b1;
      axi_r_resp_i    = 2'b00;
      axi_r_data_i    = 64'h0F0E_0D0C_0B0A_0908;
      sb.push_back('{data: 64'h0F0E_0D0C_0B0A_0908, err: 1'b0});
      @(posedge clk);
      #1 rd_addr_valid_i = 1'b0;
      @(negedge clk);
      check("lat_ar_valid", {63'd0, axi_ar_valid_o}, 64'd1);
      @(negedge clk);
      check("lat_r_ready", {63'd0, axi_r_ready_o}, 64'd1);
      check("lat_no_early_valid", {63'd0, rd_data_valid_o}, 64'd0);
      @(negedge clk);
      check("lat_valid", {63'd0, rd_data_valid_o}, 64'd1);
      rd_addr_valid_i = 1'b1;
      rd_addr_i       = 64'h20;
      rd_size_i       = 2'b10;
      axi_ar_ready_i  = 1'b0;
      axi_r_valid_i   = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check("gap_no_ar", {63'd0, axi_ar_valid_o}, 64'd0);
      end
      @(negedge clk);
      check("gap_capture", {63'd0, axi_ar_valid_o}, 64'd1);
      check("gap_ar_addr", axi_ar_addr_o, 64'h20);
      rd_addr_valid_i = 1'b0;
      axi_ar_ready_i  = 1'b1;
      @(posedge clk);
      #1 axi_ar_ready_i = 1'b0;
      axi_r_valid_i = 1'b1;
      axi_r_data_i  = 64'hAAAA_BBBB_CCCC_DDDD;
      sb.push_back('{data: 64'h0000_0000_CCCC_DDDD, err: 1'b0});
      @(posedge clk);
      #1 axi_r_valid_i = 1'b0;
      wait_sb_empty("gap_response_timeout");

      // Reset in DATA abandons the transaction; a late R beat must be ignored.
      repeat (4) @(posedge clk);
      #1;
      rd_addr_valid_i = 1'b1;
      rd_addr_i       = 64'h40;
      rd_size_i       = 2'b11;
      wait_ar_valid("rst_seq_ar_timeout", ok);
      rd_addr_valid_i = 1'b0;
      axi_ar_ready_i  = 1'b1;
      @(posedge clk);
      #1 axi_ar_ready_i = 1'b0;
      @(negedge clk);
      check("rst_seq_in_data", {63'd0, axi_r_ready_o}, 64'd1);
      rst = 1'b1;
      #1;
      check("rst_async_r_ready", {63'd0, axi_r_ready_o}, 64'd0);
      check("rst_async_ar_addr", axi_ar_addr_o, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      axi_r_valid_i = 1'b1;
      axi_r_id_i    = AxiId;
      axi_r_last_i  = 1'b1;
      axi_r_data_i  = 64'hFFFF_FFFF_FFFF_FFFF;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("post_rst_r_ready", {63'd0, axi_r_ready_o}, 64'd0);
         check("post_rst_ar_valid", {63'd0, axi_ar_valid_o}, 64'd0);
         check("post_rst_no_valid", {63'd0, rd_data_valid_o}, 64'd0);
      end
      check("post_rst_rd_data", rd_data_o, 64'd0);
      axi_r_valid_i = 1'b0;
      axi_r_last_i  = 1'b0;
      @(posedge clk);
      #1;

      do_read(vecs[6]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
